// File: rtl/jpeg_fb_writer_if.sv
// Stream interfaces for the JPEG framebuffer writer: decoded pixel input and word-write output.

interface jfw_pix_if;
    logic        valid;
    logic        accept;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] pixel_x;
    logic [15:0] pixel_y;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;

    modport master (
        output valid, width, height, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b,
        input  accept
    );

    modport slave (
        input  valid, width, height, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b,
        output accept
    );
endinterface

interface jfw_wr_if;
    logic        valid;
    logic        accept;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;

    modport master (
        output valid, addr, data, strb,
        input  accept
    );

    modport slave (
        input  valid, addr, data, strb,
        output accept
    );
endinterface

// File: rtl/jpeg_fb_writer.sv
// Writes the decoder's pixel stream into a linear RGB565 framebuffer, pairing
// even/odd neighbours into full 32-bit writes and flushing lone half-words.

module jpeg_fb_writer #(
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    jfw_pix_if.slave    inport,
    jfw_wr_if.master    outport,
    input  logic [31:0] cfg_base_addr_i,
    input  logic [15:0] cfg_stride_i,
    output logic        frame_done_o,
    output logic        idle_o
);

    localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_FLUSH,
        ACT_MERGE,
        ACT_LOAD,
        ACT_DIRECT
    } act_e;

    // Output slot
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_addr_q,  out_addr_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [3:0]  out_strb_q,  out_strb_d;

    // Held even half-word
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_addr_q,  hold_addr_d;
    logic [15:0] hold_data_q,  hold_data_d;
    logic [15:0] hold_x_q,     hold_x_d;

    // Frame tracking and idle flush timer
    logic [31:0]   count_q, count_d;
    logic [15:0]   width_q, width_d;
    logic [15:0]   height_q, height_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_done_q, frame_done_d;
    logic          idle_q, idle_d;

    logic [15:0] pix_c;
    logic [31:0] row_off_c;
    logic [31:0] byte_addr_c;
    logic [31:0] word_addr_c;
    logic [31:0] total_c;
    logic        frame_full_c;
    logic [15:0] eff_w_c;
    logic        last_col_c;
    logic        in_v_c;
    logic        slot_free_c;
    logic        pair_match_c;
    logic        accept_c;
    logic        done_c;
    act_e        act_c;
    logic        unused_c;

    // Pixel format, address generation and frame status
    always_comb begin
        pix_c        = {inport.pixel_r[7:3], inport.pixel_g[7:2], inport.pixel_b[7:3]};
        row_off_c    = 32'(inport.pixel_y) * 32'(cfg_stride_i);
        byte_addr_c  = cfg_base_addr_i + row_off_c + {15'd0, inport.pixel_x, 1'b0};
        word_addr_c  = {byte_addr_c[31:2], 2'b00};
        total_c      = 32'(width_q) * 32'(height_q);
        frame_full_c = (total_c != 32'd0) && (count_q == total_c);
        // The first pixel of a frame is judged against its own width since nothing is latched yet
        eff_w_c      = (count_q == 32'd0) ? inport.width : width_q;
        last_col_c   = (inport.pixel_x == 16'(eff_w_c - 16'd1));
        in_v_c       = inport.valid && !frame_full_c;
        slot_free_c  = !out_valid_q || outport.accept;
        pair_match_c = inport.pixel_x[0] && (word_addr_c == hold_addr_q)
                       && (inport.pixel_x == 16'(hold_x_q + 16'd1));
        unused_c     = ^{inport.pixel_r[2:0], inport.pixel_g[1:0], inport.pixel_b[2:0],
                         byte_addr_c[1:0]};
    end

    // Prioritised per-cycle action, only when the out slot can take a write
    always_comb begin
        act_c = ACT_NONE;
        if (slot_free_c) begin
            if (frame_full_c && hold_valid_q) begin
                act_c = ACT_FLUSH;
            end else if (hold_valid_q && in_v_c && pair_match_c) begin
                act_c = ACT_MERGE;
            end else if (hold_valid_q && in_v_c) begin
                act_c = ACT_FLUSH;
            end else if (hold_valid_q && !inport.valid && (timer_q == TIMER_LAST)) begin
                act_c = ACT_FLUSH;
            end else if (!hold_valid_q && in_v_c && !inport.pixel_x[0] && !last_col_c) begin
                act_c = ACT_LOAD;
            end else if (!hold_valid_q && in_v_c) begin
                act_c = ACT_DIRECT;
            end
        end
        accept_c = (act_c == ACT_MERGE) || (act_c == ACT_LOAD) || (act_c == ACT_DIRECT);
        done_c   = frame_full_c && !hold_valid_q && out_valid_q && outport.accept;
    end

    // Next-state for slot, hold, timer and frame counters
    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        hold_x_d     = hold_x_q;
        count_d      = count_q;
        width_d      = width_q;
        height_d     = height_q;
        timer_d      = timer_q;
        frame_done_d = done_c;

        if (slot_free_c) begin
            out_valid_d = 1'b0;
        end

        unique case (act_c)
            ACT_FLUSH: begin
                out_valid_d  = 1'b1;
                out_addr_d   = hold_addr_q;
                out_data_d   = {16'd0, hold_data_q};
                out_strb_d   = 4'b0011;
                hold_valid_d = 1'b0;
            end
            ACT_MERGE: begin
                out_valid_d  = 1'b1;
                out_addr_d   = hold_addr_q;
                out_data_d   = {pix_c, hold_data_q};
                out_strb_d   = 4'b1111;
                hold_valid_d = 1'b0;
            end
            ACT_LOAD: begin
                hold_valid_d = 1'b1;
                hold_addr_d  = word_addr_c;
                hold_data_d  = pix_c;
                hold_x_d     = inport.pixel_x;
            end
            ACT_DIRECT: begin
                out_valid_d = 1'b1;
                out_addr_d  = word_addr_c;
                if (inport.pixel_x[0]) begin
                    out_data_d = {pix_c, 16'd0};
                    out_strb_d = 4'b1100;
                end else begin
                    out_data_d = {16'd0, pix_c};
                    out_strb_d = 4'b0011;
                end
            end
            default: ;
        endcase

        // Idle timer runs only while a half-word waits with no input in sight
        if ((act_c != ACT_NONE && act_c != ACT_DIRECT) || inport.valid || !hold_valid_q) begin
            timer_d = '0;
        end else if (timer_q != TIMER_LAST) begin
            timer_d = timer_q + TW'(1);
        end

        if (accept_c && (count_q == 32'd0)) begin
            width_d  = inport.width;
            height_d = inport.height;
        end
        if (done_c) begin
            count_d = 32'd0;
        end else if (accept_c) begin
            count_d = count_q + 32'd1;
        end

        idle_d = !hold_valid_d && !out_valid_d && (count_d == 32'd0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= 32'd0;
            out_data_q   <= 32'd0;
            out_strb_q   <= 4'd0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 32'd0;
            hold_data_q  <= 16'd0;
            hold_x_q     <= 16'd0;
            count_q      <= 32'd0;
            width_q      <= 16'd0;
            height_q     <= 16'd0;
            timer_q      <= '0;
            frame_done_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            hold_x_q     <= hold_x_d;
            count_q      <= count_d;
            width_q      <= width_d;
            height_q     <= height_d;
            timer_q      <= timer_d;
            frame_done_q <= frame_done_d;
            idle_q       <= idle_d;
        end
    end

    assign inport.accept  = accept_c;
    assign outport.valid  = out_valid_q;
    assign outport.addr   = out_addr_q;
    assign outport.data   = out_data_q;
    assign outport.strb   = out_strb_q;
    assign frame_done_o   = frame_done_q;
    assign idle_o         = idle_q;

endmodule
